// File: rtl/ecap5_wb_arbiter_if.sv
// Bus bundle between NUM_MASTERS Wishbone requesters, the arbiter and the downstream decoder.
// slave = arbiter view; master = requesters plus decoder (environment) view.
interface ecap5_wb_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [32*NUM_MASTERS-1:0] m_wb_adr_i;
  logic [32*NUM_MASTERS-1:0] m_wb_dat_i;
  logic [31:0]               m_wb_dat_o;
  logic [4*NUM_MASTERS-1:0]  m_wb_sel_i;
  logic [NUM_MASTERS-1:0]    m_wb_we_i;
  logic [NUM_MASTERS-1:0]    m_wb_stb_i;
  logic [NUM_MASTERS-1:0]    m_wb_cyc_i;
  logic [NUM_MASTERS-1:0]    m_wb_ack_o;
  logic [NUM_MASTERS-1:0]    m_wb_stall_o;

  logic [31:0] s_wb_adr_o;
  logic [31:0] s_wb_dat_o;
  logic [31:0] s_wb_dat_i;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_we_o;
  logic        s_wb_stb_o;
  logic        s_wb_cyc_o;
  logic        s_wb_ack_i;
  logic        s_wb_stall_i;

  modport slave (
    input  m_wb_adr_i, m_wb_dat_i, m_wb_sel_i, m_wb_we_i, m_wb_stb_i, m_wb_cyc_i,
    output m_wb_dat_o, m_wb_ack_o, m_wb_stall_o,
    output s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_stb_o, s_wb_cyc_o,
    input  s_wb_dat_i, s_wb_ack_i, s_wb_stall_i
  );

  modport master (
    output m_wb_adr_i, m_wb_dat_i, m_wb_sel_i, m_wb_we_i, m_wb_stb_i, m_wb_cyc_i,
    input  m_wb_dat_o, m_wb_ack_o, m_wb_stall_o,
    input  s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_stb_o, s_wb_cyc_o,
    output s_wb_dat_i, s_wb_ack_i, s_wb_stall_i
  );
endinterface

// File: rtl/ecap5_wb_arbiter.sv
// Round-robin pipelined Wishbone arbiter; grant registered 1 cycle after cyc, held for the whole cyc period.
// Non-owners always stall; owner stalls on downstream stall or when MAX_OUTSTANDING requests are unacked.
module ecap5_wb_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  ecap5_wb_arbiter_if.slave bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [3:0]    MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          grant_idx, grant_idx_nxt;
  logic [IW-1:0]          last_idx, last_idx_nxt;
  logic [IW-1:0]          winner;
  logic [3:0]             outstanding, outstanding_nxt;
  logic                   grant_valid, owner_cyc, full, accept, ack_take, found;
  logic [NUM_MASTERS-1:0] ack_vec, stall_vec;

  assign grant_valid = (state == GRANTED);
  assign owner_cyc   = bus.m_wb_cyc_i[grant_idx];
  assign full        = (outstanding == MAX_OUT);

  // First requester after the previous owner, wrapping around.
  always_comb begin
    winner = last_idx;
    found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!found && bus.m_wb_cyc_i[(int'(last_idx) + i) % NUM_MASTERS]) begin
        winner = IW'((int'(last_idx) + i) % NUM_MASTERS);
        found  = 1'b1;
      end
    end
  end

  assign bus.s_wb_cyc_o = grant_valid & owner_cyc & ~rst_i;
  assign bus.s_wb_stb_o = bus.s_wb_cyc_o & bus.m_wb_stb_i[grant_idx] & ~full;
  assign bus.s_wb_adr_o = bus.m_wb_adr_i[int'(grant_idx)*32 +: 32];
  assign bus.s_wb_dat_o = bus.m_wb_dat_i[int'(grant_idx)*32 +: 32];
  assign bus.s_wb_sel_o = bus.m_wb_sel_i[int'(grant_idx)*4 +: 4];
  assign bus.s_wb_we_o  = bus.m_wb_we_i[grant_idx];
  assign bus.m_wb_dat_o = bus.s_wb_dat_i;

  assign accept   = bus.s_wb_stb_o & ~bus.s_wb_stall_i;
  // Acks with nothing outstanding (stale acks after an abort) are swallowed here.
  assign ack_take = bus.s_wb_ack_i & grant_valid & (outstanding != 4'd0);

  always_comb begin
    ack_vec   = '0;
    stall_vec = '1;
    if (grant_valid && !rst_i) begin
      ack_vec[grant_idx]   = ack_take;
      stall_vec[grant_idx] = bus.s_wb_stall_i | full;
    end
  end

  assign bus.m_wb_ack_o   = ack_vec;
  assign bus.m_wb_stall_o = stall_vec;

  always_comb begin
    state_nxt       = state;
    grant_idx_nxt   = grant_idx;
    last_idx_nxt    = last_idx;
    outstanding_nxt = outstanding;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = GRANTED;
          grant_idx_nxt = winner;
        end
      end
      GRANTED: begin
        if (!owner_cyc) begin
          state_nxt       = IDLE;
          last_idx_nxt    = grant_idx;
          outstanding_nxt = 4'd0;
        end else if (accept && !ack_take) begin
          outstanding_nxt = outstanding + 4'd1;
        end else if (!accept && ack_take) begin
          outstanding_nxt = outstanding - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      grant_idx   <= '0;
      last_idx    <= LAST_RST;
      outstanding <= 4'd0;
    end else begin
      state       <= state_nxt;
      grant_idx   <= grant_idx_nxt;
      last_idx    <= last_idx_nxt;
      outstanding <= outstanding_nxt;
    end
  end
endmodule

// File: doc/ecap5_wb_arbiter.md
Name: ecap5_wb_arbiter

Overview:
- Pipelined Wishbone B4 arbiter that shares one downstream bus (the SoC address decoder feeding the BRAM and UART) among NUM_MASTERS requesters, e.g. the core plus a future debug/DMA master.
- Grants are round-robin and held for a whole cycle (cyc) period.
- Tracks outstanding requests so that acks are routed only to the owner, and limits pipelining depth.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests per grant (1..15).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- m_wb_adr_i  in  32*NUM_MASTERS  master addresses; master k occupies bits [32k+31:32k]
- m_wb_dat_i  in  32*NUM_MASTERS  master write data
- m_wb_dat_o  out  32  read data, broadcast to all masters
- m_wb_sel_i  in  4*NUM_MASTERS  byte selects
- m_wb_we_i  in  NUM_MASTERS  write enables
- m_wb_stb_i  in  NUM_MASTERS  strobes
- m_wb_cyc_i  in  NUM_MASTERS  cycle requests
- m_wb_ack_o  out  NUM_MASTERS  per-master ack
- m_wb_stall_o  out  NUM_MASTERS  per-master stall
- s_wb_adr_o  out  32  to decoder
- s_wb_dat_o  out  32  to decoder
- s_wb_dat_i  in  32  from decoder
- s_wb_sel_o  out  4  to decoder
- s_wb_we_o  out  1  to decoder
- s_wb_stb_o  out  1  to decoder
- s_wb_cyc_o  out  1  to decoder
- s_wb_ack_i  in  1  from decoder
- s_wb_stall_i  in  1  from decoder

Behaviour:
- State registers:
  - grant_valid (1b)
  - grant_idx (index width)
  - last_idx (index width)
  - outstanding (4b)
- Reset values:
  - grant_valid=0, last_idx=NUM_MASTERS-1, outstanding=0.
  - Outputs during reset: s_wb_cyc_o=0, s_wb_stb_o=0, all m_wb_ack_o=0, all m_wb_stall_o=1.
- States:
  - IDLE (grant_valid=0).
  - GRANTED (grant_valid=1).
- IDLE -> GRANTED:
  - Taken when any m_wb_cyc_i is high.
  - The winner is the first requesting index searching last_idx+1, last_idx+2, ... modulo NUM_MASTERS.
  - grant_idx is registered, so the grant is visible 1 cycle after cyc rises; there is no combinational grant.
- GRANTED -> IDLE:
  - Taken on the first cycle the owner has m_wb_cyc_i[grant_idx]=0.
  - On that edge: last_idx<=grant_idx, outstanding<=0.
  - Minimum 1 IDLE cycle between grants, so the bus turnaround is 1 cycle.
- Forwarding while GRANTED (combinational from grant_idx):
  - adr, dat, sel, we, stb pass from the owner to s_wb_*.
  - s_wb_cyc_o = m_wb_cyc_i[grant_idx].
  - In IDLE: s_wb_cyc_o=0 and s_wb_stb_o=0. s_wb_adr_o/dat_o/sel_o/we_o are don't-care.
- Stall:
  - Owner: m_wb_stall_o = s_wb_stall_i | (outstanding==MAX_OUTSTANDING).
  - When outstanding is full, s_wb_stb_o is forced to 0.
  - All non-owners, and every master in IDLE: m_wb_stall_o=1.
- Ack:
  - m_wb_ack_o[grant_idx] = s_wb_ack_i & grant_valid. All other masters see 0.
  - An ack arriving while outstanding==0, or in IDLE, is dropped.
- m_wb_dat_o = s_wb_dat_i unconditionally.
- Outstanding counter:
  - +1 when a request is accepted (s_wb_stb_o & ~s_wb_stall_i).
  - -1 when s_wb_ack_i is received and outstanding>0.
  - Simultaneous accept and ack: count unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Abort:
  - If the owner drops cyc with outstanding>0, the transfer is aborted: s_wb_cyc_o falls in the same cycle and the counter clears.
  - Late acks are dropped, per the ack rule above.
- Reset mid-transfer: all state returns to reset values on the next edge; s_wb_cyc_o=0 in the following cycle.
- Stability: a non-owner holding cyc high waits indefinitely without any state change; it sees only stall.

Test Plan:
- Reset:
  - Stimulus: rst_i high for 2 cycles.
  - Required: s_wb_cyc_o=0, m_wb_stall_o=all ones, m_wb_ack_o=0.
  - After release with m0 cyc+stb and adr=0x00000010: s_wb_cyc_o rises 1 cycle later, s_wb_adr_o=0x00000010.
- Round-robin:
  - Stimulus: m0 and m1 assert cyc in the same cycle.
  - Required: m0 is granted first (last_idx reset to 1). After m0 drops cyc there is 1 IDLE cycle, then m1 is granted. If m0 re-requests afterwards, m1 must release before m0 is granted.
- Pipelining limit:
  - Stimulus: owner issues 6 back-to-back stb with s_wb_stall_i=0 and no acks, MAX_OUTSTANDING=4.
  - Required: exactly 4 accepted. m_wb_stall_o[owner]=1 from the 5th. After 1 ack, 1 more is accepted.
- Ack routing:
  - Stimulus: m1 granted, 3 reads, acks carrying dat 0xA5A5A5A5.
  - Required: m_wb_ack_o=2'b10 on each ack, m0 never sees an ack, and outstanding returns to 0.
- Abort:
  - Stimulus: owner drops cyc with 2 outstanding.
  - Required: s_wb_cyc_o=0 in the same cycle. A late s_wb_ack_i is not forwarded. The next requester is granted after 1 IDLE cycle.
- Simultaneous events:
  - Stimulus: accept and ack in the same cycle at outstanding=3.
  - Required: outstanding stays 3. rst_i pulsed mid-burst: grant drops and s_wb_cyc_o=0 on the following cycle.
